// File: rtl/debug_wb_serializer_pkg.sv
// Shared definitions for the debug writeback serializer.
//   debug_wb_t          : one buffered register write {pc, rd, wdata}
//   DEBUG_WB_WEN_ALL    : byte enables driven while a write is emitted
//   DEBUG_WB_WEN_NONE   : byte enables driven in idle cycles
package debug_wb_serializer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } debug_wb_t;

  localparam logic [3:0] DEBUG_WB_WEN_ALL  = 4'hf;
  localparam logic [3:0] DEBUG_WB_WEN_NONE = 4'h0;

endpackage

// File: rtl/debug_wb_serializer_fifo.sv
// dbg_wb_fifo: storage for the debug writeback serializer.
// Dual-write, single-read register array. Up to two entries are written per
// cycle (data0 at wptr, data1 at wptr+1); one entry is read per cycle.
// The caller guarantees push count never exceeds the free space and pop is
// only asserted while the FIFO holds data.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   i_push_cnt       : number of entries to write this cycle (0..2)
//   i_push_data0/1   : entries to write, data0 is the older one
//   i_pop            : consume the entry at the read pointer
//   o_rd_data        : entry at the read pointer (combinational)
//   o_count          : registered occupancy
module dbg_wb_fifo
  import debug_wb_serializer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    i_push_cnt,
  input  debug_wb_t     i_push_data0,
  input  debug_wb_t     i_push_data1,
  input  logic          i_pop,
  output debug_wb_t     o_rd_data,
  output logic [CW-1:0] o_count
);

  debug_wb_t     r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wptr_p1;

  assign w_wptr_p1 = r_wptr + PW'(1);

  // Storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) r_mem[r_wptr]    <= i_push_data0;
    if (i_push_cnt == 2'd2) r_mem[w_wptr_p1] <= i_push_data1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(i_push_cnt);
      if (i_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;

endmodule

// File: rtl/debug_wb_serializer.sv
// debug_wb_serializer: commit-order serializer from the dual-issue writeback
// stage onto the single-lane debug writeback port.
// Ports:
//   clk, resetn          : core clock, synchronous active-low reset
//   wb_valid_i[1:0]      : per-slot retire valid, slot 0 is older
//   wb_pc_i/rd_i/wdata_i : per-slot retired PC, destination, write data
//   stall_o              : fewer than two free entries, core must hold
//   debug_wb_*           : registered emitted write, wen = f when valid
//   empty_o              : nothing buffered and nothing being emitted
//   overflow_o           : sticky, a push arrived with no room for it
module debug_wb_serializer
  import debug_wb_serializer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       wb_valid_i,
  input  logic [1:0][31:0] wb_pc_i,
  input  logic [1:0][4:0]  wb_rd_i,
  input  logic [1:0][31:0] wb_wdata_i,
  output logic             stall_o,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_wen,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_q0;
  logic          w_q1;
  debug_wb_t     w_slot0;
  debug_wb_t     w_slot1;
  debug_wb_t     w_push_d0;
  logic [1:0]    w_nreq;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  logic          w_drop;
  logic [1:0]    w_push_cnt;
  logic          w_pop;
  debug_wb_t     w_rd_data;

  logic [31:0]   r_pc;
  logic [3:0]    r_wen;
  logic [4:0]    r_wnum;
  logic [31:0]   r_wdata;
  logic          r_overflow;

  // A slot writing x0 carries no architectural effect and is discarded.
  assign w_q0    = wb_valid_i[0] && (wb_rd_i[0] != 5'd0);
  assign w_q1    = wb_valid_i[1] && (wb_rd_i[1] != 5'd0);
  assign w_slot0 = {wb_pc_i[0], wb_rd_i[0], wb_wdata_i[0]};
  assign w_slot1 = {wb_pc_i[1], wb_rd_i[1], wb_wdata_i[1]};

  // Compaction: when slot 0 is discarded, slot 1 takes the first entry.
  // With a single push the FIFO ignores data1, so it can stay slot 1.
  assign w_push_d0 = w_q0 ? w_slot0 : w_slot1;
  assign w_nreq    = {1'b0, w_q0} + {1'b0, w_q1};

  // Room is judged on the registered count only; a same-cycle pop does not
  // create space, which keeps the read and write pointers from colliding.
  assign w_free     = CW'(DEPTH) - w_count;
  assign w_drop     = CW'(w_nreq) > w_free;
  assign w_push_cnt = w_drop ? w_free[1:0] : w_nreq;
  assign w_pop      = (w_count != '0);

  dbg_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .i_push_cnt   (w_push_cnt),
    .i_push_data0 (w_push_d0),
    .i_push_data1 (w_slot1),
    .i_pop        (w_pop),
    .o_rd_data    (w_rd_data),
    .o_count      (w_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc    <= '0;
      r_wen   <= DEBUG_WB_WEN_NONE;
      r_wnum  <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_pc    <= w_rd_data.pc;
      r_wen   <= DEBUG_WB_WEN_ALL;
      r_wnum  <= w_rd_data.rd;
      r_wdata <= w_rd_data.wdata;
    end else begin
      r_wen   <= DEBUG_WB_WEN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)     r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign stall_o           = w_count > CW'(DEPTH - 2);
  assign empty_o           = (w_count == '0) && (r_wen == DEBUG_WB_WEN_NONE);
  assign overflow_o        = r_overflow;
  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_wen   = r_wen;
  assign debug_wb_rf_wnum  = r_wnum;
  assign debug_wb_rf_wdata = r_wdata;

endmodule

// File: tb/tb_debug_wb_serializer.sv
// Directed bench for debug_wb_serializer with a queue reference model that
// predicts every output after every clock edge.
module tb_debug_wb_serializer;
  import debug_wb_serializer_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             resetn;
  logic [1:0]       wb_valid_i;
  logic [1:0][31:0] wb_pc_i;
  logic [1:0][4:0]  wb_rd_i;
  logic [1:0][31:0] wb_wdata_i;
  logic             stall_o;
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;
  logic [31:0]      debug_wb_rf_wdata;
  logic             empty_o;
  logic             overflow_o;

  always #5 clk = ~clk;

  debug_wb_serializer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_valid_i        (wb_valid_i),
    .wb_pc_i           (wb_pc_i),
    .wb_rd_i           (wb_rd_i),
    .wb_wdata_i        (wb_wdata_i),
    .stall_o           (stall_o),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .empty_o           (empty_o),
    .overflow_o        (overflow_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_emit   = 0;

  debug_wb_t   m_q[$];
  logic [31:0] e_pc    = '0;
  logic [4:0]  e_wnum  = '0;
  logic [31:0] e_wdata = '0;
  logic [3:0]  e_wen   = '0;
  logic        e_ov    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the reference model across one edge, then clock the DUT and
  // compare every output one time unit after the edge.
  task automatic tick();
    debug_wb_t acc[$];
    int free;
    if (!resetn) begin
      m_q.delete();
      e_pc = '0; e_wnum = '0; e_wdata = '0; e_wen = 4'h0; e_ov = 1'b0;
    end else begin
      if (wb_valid_i[0] && wb_rd_i[0] != 5'd0)
        acc.push_back({wb_pc_i[0], wb_rd_i[0], wb_wdata_i[0]});
      if (wb_valid_i[1] && wb_rd_i[1] != 5'd0)
        acc.push_back({wb_pc_i[1], wb_rd_i[1], wb_wdata_i[1]});
      free = DEPTH - m_q.size();
      if (acc.size() > free) e_ov = 1'b1;
      if (m_q.size() != 0) begin
        debug_wb_t h;
        h = m_q.pop_front();
        e_pc = h.pc; e_wnum = h.rd; e_wdata = h.wdata; e_wen = 4'hf;
      end else begin
        e_wen = 4'h0;
      end
      for (int i = 0; i < acc.size() && i < free; i++) begin
        m_q.push_back(acc[i]);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    chk("wen",      32'(debug_wb_rf_wen),   32'(e_wen));
    chk("pc",       debug_wb_pc,            e_pc);
    chk("wnum",     32'(debug_wb_rf_wnum),  32'(e_wnum));
    chk("wdata",    debug_wb_rf_wdata,      e_wdata);
    chk("stall",    32'(stall_o),           32'(m_q.size() > DEPTH - 2));
    chk("empty",    32'(empty_o),           32'(m_q.size() == 0 && e_wen == 4'h0));
    chk("overflow", 32'(overflow_o),        32'(e_ov));
    if (debug_wb_rf_wen == 4'hf) n_emit++;
  endtask

  task automatic set_slot(input int k, input logic v, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [31:0] d);
    wb_valid_i[k] = v;
    wb_pc_i[k]    = pc;
    wb_rd_i[k]    = rd;
    wb_wdata_i[k] = d;
  endtask

  task automatic idle();
    wb_valid_i = 2'b00;
  endtask

  task automatic dual(input int n);
    set_slot(0, 1'b1, 32'h1000 + 32'(8 * n), 5'(n % 31 + 1), $urandom);
    set_slot(1, 1'b1, 32'h1004 + 32'(8 * n), 5'((n + 7) % 31 + 1), $urandom);
  endtask

  task automatic drain(input string tag);
    int i = 0;
    idle();
    while (empty_o !== 1'b1 && i < 64) begin
      tick();
      i++;
    end
    chk(tag, 32'(empty_o), 32'h1);
  endtask

  initial begin
    int n_retire;
    int cyc;

    // Reset values
    resetn = 1'b0;
    wb_valid_i = '0; wb_pc_i = '0; wb_rd_i = '0; wb_wdata_i = '0;
    tick();
    tick();
    chk("rst_pc",    debug_wb_pc,             32'h0);
    chk("rst_wen",   32'(debug_wb_rf_wen),    32'h0);
    chk("rst_wnum",  32'(debug_wb_rf_wnum),   32'h0);
    chk("rst_wdata", debug_wb_rf_wdata,       32'h0);
    chk("rst_stall", 32'(stall_o),            32'h0);
    chk("rst_empty", 32'(empty_o),            32'h1);
    chk("rst_ovf",   32'(overflow_o),         32'h0);
    resetn = 1'b1;

    // Single write: two-cycle latency, wen drops and pc holds afterwards
    set_slot(0, 1'b1, 32'hbfc00000, 5'd2, 32'h1234);
    set_slot(1, 1'b0, 32'h0, 5'd0, 32'h0);
    tick();
    idle();
    chk("t1_c2_wen",   32'(debug_wb_rf_wen),  32'h0);
    chk("t1_c2_empty", 32'(empty_o),          32'h0);
    tick();
    chk("t1_c3_wen",   32'(debug_wb_rf_wen),  32'hf);
    chk("t1_c3_wnum",  32'(debug_wb_rf_wnum), 32'd2);
    chk("t1_c3_wdata", debug_wb_rf_wdata,     32'h1234);
    chk("t1_c3_pc",    debug_wb_pc,           32'hbfc00000);
    tick();
    chk("t1_c4_wen",   32'(debug_wb_rf_wen),  32'h0);
    chk("t1_c4_pc",    debug_wb_pc,           32'hbfc00000);

    // Ordering and compaction: rd 5, then 3, 4
    set_slot(0, 1'b1, 32'h100, 5'd0, 32'haaaa);
    set_slot(1, 1'b1, 32'h104, 5'd5, 32'h55);
    tick();
    set_slot(0, 1'b1, 32'h108, 5'd3, 32'h33);
    set_slot(1, 1'b1, 32'h10c, 5'd4, 32'h44);
    tick();
    idle();
    chk("t2_first_wen",  32'(debug_wb_rf_wen),  32'hf);
    chk("t2_first_rd",   32'(debug_wb_rf_wnum), 32'd5);
    chk("t2_first_pc",   debug_wb_pc,           32'h104);
    tick();
    chk("t2_second_rd",  32'(debug_wb_rf_wnum), 32'd3);
    tick();
    chk("t2_third_rd",   32'(debug_wb_rf_wnum), 32'd4);
    chk("t2_third_data", debug_wb_rf_wdata,     32'h44);
    tick();
    chk("t2_done_wen",   32'(debug_wb_rf_wen),  32'h0);

    // Backpressure: count goes 2,3,4,5,6,7 under sustained dual retire
    for (int i = 0; i < 6; i++) begin
      dual(i);
      tick();
      if (i == 4) chk("t3_stall_at6", 32'(stall_o), 32'h0);
      if (i == 5) chk("t3_stall_at7", 32'(stall_o), 32'h1);
    end
    for (int i = 6; i < 40; i++) begin
      if (!stall_o) dual(i);
      else idle();
      tick();
    end
    drain("t3_drain");
    chk("t3_no_ovf",  32'(overflow_o), 32'h0);
    chk("t3_sb_empty", 32'(m_q.size()), 32'h0);

    // Overflow: forced dual push at count 7 keeps one entry, drops one
    for (int i = 0; i < 6; i++) begin
      dual(100 + i);
      tick();
    end
    chk("t4_stall_pre", 32'(stall_o), 32'h1);
    dual(200);
    tick();
    idle();
    chk("t4_ovf_set", 32'(overflow_o), 32'h1);
    drain("t4_drain");
    chk("t4_ovf_sticky", 32'(overflow_o), 32'h1);

    // Reset mid-drain
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t5_ovf_clr", 32'(overflow_o), 32'h0);
    for (int i = 0; i < 5; i++) begin
      dual(300 + i);
      tick();
    end
    idle();
    chk("t5_loaded_stall", 32'(stall_o), 32'h0);
    chk("t5_loaded_wen",   32'(debug_wb_rf_wen), 32'hf);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("t5_rst_wen",   32'(debug_wb_rf_wen), 32'h0);
    chk("t5_rst_empty", 32'(empty_o),         32'h1);
    chk("t5_rst_stall", 32'(stall_o),         32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_no_stale", 32'(debug_wb_rf_wen), 32'h0);
    end

    // Random dual-issue stream, 1000 retires, honoring stall
    n_acc = 0;
    n_emit = 0;
    n_retire = 0;
    cyc = 0;
    while (n_retire < 1000 && cyc < 5000) begin
      if (!stall_o) begin
        for (int k = 0; k < 2; k++) begin
          logic v;
          v = ($urandom_range(0, 3) != 0);
          set_slot(k, v, $urandom, 5'($urandom_range(0, 31)), $urandom);
          if (v) n_retire++;
        end
      end else begin
        idle();
      end
      tick();
      cyc++;
    end
    chk("t6_budget", 32'(cyc < 5000), 32'h1);
    drain("t6_drain");
    chk("t6_count",   32'(n_emit),     32'(n_acc));
    chk("t6_no_ovf",  32'(overflow_o), 32'h0);
    chk("t6_sb_empty", 32'(m_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
